psram_sched: RTL and testbench

- Sequencer and arbiter in front of psram_core.
- After reset it runs the PSRAM power-up sequence: a tPU wait, then the global reset command 8'hFF, then a mode-register write.
- After init it shares the core between one software config port (register-file command path) and two 64-bit bus ports.
- It drives the core's xfer_valid/rdwr and cfg_* inputs and returns read data and completion to the winning requester.

---
 rtl/psram_sched_pkg.sv | 37 +++
 rtl/psram_rr_arb2.sv | 39 +++
 rtl/psram_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_psram_sched.sv | 514 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_sched_pkg.sv
// State, owner and command encodings shared by the PSRAM scheduler and its arbiter.
package psram_sched_pkg;

    localparam logic [2:0] ST_RST_WAIT = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_ISSUE    = 3'd2;
    localparam logic [2:0] ST_WAIT_LO  = 3'd3;
    localparam logic [2:0] ST_WAIT_HI  = 3'd4;

    // Who owns the command currently in flight
    localparam logic [2:0] OWN_INIT_RST = 3'd0;
    localparam logic [2:0] OWN_INIT_MR  = 3'd1;
    localparam logic [2:0] OWN_SW       = 3'd2;
    localparam logic [2:0] OWN_P0       = 3'd3;
    localparam logic [2:0] OWN_P1       = 3'd4;

    localparam int unsigned GNT_SW = 0;
    localparam int unsigned GNT_P0 = 1;
    localparam int unsigned GNT_P1 = 2;

    localparam logic [7:0]  CMD_GRST    = 8'hFF;
    localparam logic [7:0]  MR_WCMD_DEF = 8'hC0;
    localparam logic [31:0] MR_ADDR_DEF = 32'h0000_0000;
    localparam logic [7:0]  MR_DATA_DEF = 8'h00;

    typedef struct packed {
        logic        rdwr;
        logic        cflg;
        logic [7:0]  ccmd;
        logic [31:0] cfg_addr;
        logic [7:0]  cfg_wdata;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } cmd_t;

endpackage

// File: rtl/psram_rr_arb2.sv
// Two-port round-robin arbiter with a fixed-priority software override.
module psram_rr_arb2
    import psram_sched_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic       sw_req_i,
    input  logic [1:0] req_i,
    output logic [2:0] gnt_o
);

    // ptr_q = 0 favours p0 on a tie, 1 favours p1
    logic ptr_q;

    always_comb begin
        gnt_o = 3'b000;
        if (en_i) begin
            if (sw_req_i) begin
                gnt_o[GNT_SW] = 1'b1;
            end else if (req_i[0] && (!req_i[1] || !ptr_q)) begin
                gnt_o[GNT_P0] = 1'b1;
            end else if (req_i[1]) begin
                gnt_o[GNT_P1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= 1'b0;
        end else if (gnt_o[GNT_P0]) begin
            ptr_q <= 1'b1;
        end else if (gnt_o[GNT_P1]) begin
            ptr_q <= 1'b0;
        end
    end

endmodule

// File: rtl/psram_sched.sv
// Power-up sequencer and request arbiter sitting in front of psram_core.
module psram_sched
    import psram_sched_pkg::*;
#(
    parameter logic [15:0] INIT_DLY = 16'd600,
    parameter logic [7:0]  MR_WCMD  = MR_WCMD_DEF,
    parameter logic [31:0] MR_ADDR  = MR_ADDR_DEF,
    parameter logic [7:0]  MR_DATA  = MR_DATA_DEF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        init_en_i,
    output logic        init_done_o,
    input  logic        sw_req_i,
    output logic        sw_ack_o,
    input  logic        sw_rdwr_i,
    input  logic [7:0]  sw_ccmd_i,
    input  logic [31:0] sw_addr_i,
    input  logic [7:0]  sw_data_i,
    output logic [7:0]  sw_rdata_o,
    input  logic        p0_valid_i,
    output logic        p0_ready_o,
    input  logic        p0_rdwr_i,
    input  logic [31:0] p0_addr_i,
    input  logic [63:0] p0_wdata_i,
    input  logic [7:0]  p0_wmask_i,
    output logic        p0_rvalid_o,
    output logic [63:0] p0_rdata_o,
    input  logic        p1_valid_i,
    output logic        p1_ready_o,
    input  logic        p1_rdwr_i,
    input  logic [31:0] p1_addr_i,
    input  logic [63:0] p1_wdata_i,
    input  logic [7:0]  p1_wmask_i,
    output logic        p1_rvalid_o,
    output logic [63:0] p1_rdata_o,
    output logic        core_valid_o,
    output logic        core_rdwr_o,
    input  logic        core_ready_i,
    output logic        core_cflg_o,
    output logic [7:0]  core_ccmd_o,
    output logic [31:0] core_cfg_addr_o,
    output logic [7:0]  core_cfg_wdata_o,
    input  logic [7:0]  core_cfg_rdata_i,
    output logic [31:0] core_addr_o,
    output logic [63:0] core_wdata_o,
    output logic [7:0]  core_wmask_o,
    input  logic [63:0] core_rdata_i,
    output logic        busy_o
);

    logic [2:0]  state_q, state_d, owner_q, owner_d, gnt;
    logic [15:0] cnt_q;
    cmd_t        cmd_q, cmd_d;
    logic        core_valid_q, valid_d, init_done_q, busy_q;
    logic        sw_ack_q, p0_rvalid_q, p1_rvalid_q;
    logic [7:0]  sw_rdata_q;
    logic [63:0] p0_rdata_q, p1_rdata_q;
    logic        dly_done;

    assign dly_done = (cnt_q == INIT_DLY - 16'd1);

    psram_rr_arb2 u_arb (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     ((state_q == ST_IDLE) && init_done_q),
        .sw_req_i (sw_req_i),
        .req_i    ({p1_valid_i, p0_valid_i}),
        .gnt_o    (gnt)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cmd_d   = cmd_q;
        valid_d = core_valid_q;
        case (state_q)
            ST_RST_WAIT: begin
                if (dly_done) begin
                    if (init_en_i) begin
                        state_d    = ST_ISSUE;
                        owner_d    = OWN_INIT_RST;
                        valid_d    = 1'b1;
                        cmd_d      = '0;
                        cmd_d.cflg = 1'b1;
                        cmd_d.ccmd = CMD_GRST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (|gnt) begin
                    state_d = ST_ISSUE;
                    valid_d = 1'b1;
                    cmd_d   = '0;
                end
                unique case (gnt)
                    3'b001: begin
                        owner_d         = OWN_SW;
                        cmd_d.rdwr      = sw_rdwr_i;
                        cmd_d.cflg      = 1'b1;
                        cmd_d.ccmd      = sw_ccmd_i;
                        cmd_d.cfg_addr  = sw_addr_i;
                        cmd_d.cfg_wdata = sw_data_i;
                    end
                    3'b010: begin
                        owner_d     = OWN_P0;
                        cmd_d.rdwr  = p0_rdwr_i;
                        cmd_d.addr  = p0_addr_i;
                        cmd_d.wdata = p0_wdata_i;
                        cmd_d.wmask = p0_wmask_i;
                    end
                    3'b100: begin
                        owner_d     = OWN_P1;
                        cmd_d.rdwr  = p1_rdwr_i;
                        cmd_d.addr  = p1_addr_i;
                        cmd_d.wdata = p1_wdata_i;
                        cmd_d.wmask = p1_wmask_i;
                    end
                    default: ;
                endcase
            end
            // The core only samples valid on its own trigger, so hold it until ready drops
            ST_ISSUE: begin
                if (!core_ready_i) begin
                    valid_d = 1'b0;
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (core_ready_i) state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (owner_q == OWN_INIT_RST) begin
                    state_d         = ST_ISSUE;
                    owner_d         = OWN_INIT_MR;
                    valid_d         = 1'b1;
                    cmd_d           = '0;
                    cmd_d.cflg      = 1'b1;
                    cmd_d.ccmd      = MR_WCMD;
                    cmd_d.cfg_addr  = MR_ADDR;
                    cmd_d.cfg_wdata = MR_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_RST_WAIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_RST_WAIT;
            owner_q      <= OWN_INIT_RST;
            cmd_q        <= '0;
            core_valid_q <= 1'b0;
            cnt_q        <= 16'd0;
            init_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            sw_ack_q     <= 1'b0;
            p0_rvalid_q  <= 1'b0;
            p1_rvalid_q  <= 1'b0;
            sw_rdata_q   <= 8'h00;
            p0_rdata_q   <= 64'h0;
            p1_rdata_q   <= 64'h0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cmd_q        <= cmd_d;
            core_valid_q <= valid_d;
            busy_q       <= (state_d != ST_IDLE);
            sw_ack_q     <= 1'b0;
            p0_rvalid_q  <= 1'b0;
            p1_rvalid_q  <= 1'b0;
            if (state_q == ST_RST_WAIT) begin
                if (!dly_done) cnt_q <= cnt_q + 16'd1;
                else if (!init_en_i) init_done_q <= 1'b1;
            end
            // Ready returning high marks the end of the transfer including recovery
            if (state_q == ST_WAIT_LO && core_ready_i) begin
                case (owner_q)
                    OWN_SW: begin
                        sw_rdata_q <= core_cfg_rdata_i;
                        sw_ack_q   <= 1'b1;
                    end
                    OWN_P0: begin
                        p0_rdata_q  <= core_rdata_i;
                        p0_rvalid_q <= 1'b1;
                    end
                    OWN_P1: begin
                        p1_rdata_q  <= core_rdata_i;
                        p1_rvalid_q <= 1'b1;
                    end
                    OWN_INIT_MR: init_done_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign init_done_o      = init_done_q;
    assign busy_o           = busy_q;
    assign sw_ack_o         = sw_ack_q;
    assign sw_rdata_o       = sw_rdata_q;
    assign p0_ready_o       = gnt[GNT_P0];
    assign p1_ready_o       = gnt[GNT_P1];
    assign p0_rvalid_o      = p0_rvalid_q;
    assign p1_rvalid_o      = p1_rvalid_q;
    assign p0_rdata_o       = p0_rdata_q;
    assign p1_rdata_o       = p1_rdata_q;
    assign core_valid_o     = core_valid_q;
    assign core_rdwr_o      = cmd_q.rdwr;
    assign core_cflg_o      = cmd_q.cflg;
    assign core_ccmd_o      = cmd_q.ccmd;
    assign core_cfg_addr_o  = cmd_q.cfg_addr;
    assign core_cfg_wdata_o = cmd_q.cfg_wdata;
    assign core_addr_o      = cmd_q.addr;
    assign core_wdata_o     = cmd_q.wdata;
    assign core_wmask_o     = cmd_q.wmask;

endmodule

// File: tb/tb_psram_sched.sv
// Directed bench for psram_sched with a small behavioural psram_core handshake model.
module tb_psram_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        init_en = 1'b1;
    logic        init_done, busy;
    logic        sw_req = 1'b0, sw_ack, sw_rdwr = 1'b0;
    logic [7:0]  sw_ccmd = 8'h00, sw_data = 8'h00, sw_rdata;
    logic [31:0] sw_addr = 32'h0;
    logic        p0_valid = 1'b0, p0_ready, p0_rdwr = 1'b0, p0_rvalid;
    logic [31:0] p0_addr = 32'h0;
    logic [63:0] p0_wdata = 64'h0, p0_rdata;
    logic [7:0]  p0_wmask = 8'h00;
    logic        p1_valid = 1'b0, p1_ready, p1_rdwr = 1'b0, p1_rvalid;
    logic [31:0] p1_addr = 32'h0;
    logic [63:0] p1_wdata = 64'h0, p1_rdata;
    logic [7:0]  p1_wmask = 8'h00;
    logic        core_valid, core_rdwr, core_ready, core_cflg;
    logic [7:0]  core_ccmd, core_cfg_wdata, core_cfg_rdata, core_wmask;
    logic [31:0] core_cfg_addr, core_addr;
    logic [63:0] core_wdata, core_rdata;

    int checks = 0;
    int errors = 0;

    assign core_rdata     = 64'h1122334455667788;
    assign core_cfg_rdata = 8'h8D;

    always #5 clk = ~clk;

    psram_sched #(
        .INIT_DLY (16'd16)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .init_en_i        (init_en),
        .init_done_o      (init_done),
        .sw_req_i         (sw_req),
        .sw_ack_o         (sw_ack),
        .sw_rdwr_i        (sw_rdwr),
        .sw_ccmd_i        (sw_ccmd),
        .sw_addr_i        (sw_addr),
        .sw_data_i        (sw_data),
        .sw_rdata_o       (sw_rdata),
        .p0_valid_i       (p0_valid),
        .p0_ready_o       (p0_ready),
        .p0_rdwr_i        (p0_rdwr),
        .p0_addr_i        (p0_addr),
        .p0_wdata_i       (p0_wdata),
        .p0_wmask_i       (p0_wmask),
        .p0_rvalid_o      (p0_rvalid),
        .p0_rdata_o       (p0_rdata),
        .p1_valid_i       (p1_valid),
        .p1_ready_o       (p1_ready),
        .p1_rdwr_i        (p1_rdwr),
        .p1_addr_i        (p1_addr),
        .p1_wdata_i       (p1_wdata),
        .p1_wmask_i       (p1_wmask),
        .p1_rvalid_o      (p1_rvalid),
        .p1_rdata_o       (p1_rdata),
        .core_valid_o     (core_valid),
        .core_rdwr_o      (core_rdwr),
        .core_ready_i     (core_ready),
        .core_cflg_o      (core_cflg),
        .core_ccmd_o      (core_ccmd),
        .core_cfg_addr_o  (core_cfg_addr),
        .core_cfg_wdata_o (core_cfg_wdata),
        .core_cfg_rdata_i (core_cfg_rdata),
        .core_addr_o      (core_addr),
        .core_wdata_o     (core_wdata),
        .core_wmask_o     (core_wmask),
        .core_rdata_i     (core_rdata),
        .busy_o           (busy)
    );

    // Core model: idle-high ready, drops ready after seeing valid, raises it 4 cycles later
    int          xfer_count = 0;
    int          model_err = 0;
    logic [1:0]  m_state;
    int          m_cnt;
    logic [154:0] snap;
    logic        log_cflg [32];
    logic        log_rdwr [32];
    logic [7:0]  log_ccmd [32];
    logic [31:0] log_addr [32];
    logic [31:0] log_cfg_addr [32];
    logic [7:0]  log_cfg_wdata [32];
    logic [63:0] log_wdata [32];
    logic [7:0]  log_wmask [32];
    logic [154:0] fields;

    assign fields = {core_rdwr, core_cflg, core_ccmd, core_cfg_addr, core_cfg_wdata,
                     core_addr, core_wdata, core_wmask};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_ready <= 1'b1;
            m_state    <= 2'd0;
            m_cnt      <= 0;
        end else begin
            case (m_state)
                2'd0: if (core_valid) begin
                    snap                              <= fields;
                    log_cflg[xfer_count[4:0]]         <= core_cflg;
                    log_rdwr[xfer_count[4:0]]         <= core_rdwr;
                    log_ccmd[xfer_count[4:0]]         <= core_ccmd;
                    log_addr[xfer_count[4:0]]         <= core_addr;
                    log_cfg_addr[xfer_count[4:0]]     <= core_cfg_addr;
                    log_cfg_wdata[xfer_count[4:0]]    <= core_cfg_wdata;
                    log_wdata[xfer_count[4:0]]        <= core_wdata;
                    log_wmask[xfer_count[4:0]]        <= core_wmask;
                    xfer_count                        <= xfer_count + 1;
                    core_ready                        <= 1'b0;
                    m_cnt                             <= 3;
                    m_state                           <= 2'd1;
                end
                2'd1: begin
                    if (fields !== snap) model_err <= model_err + 1;
                    if (m_cnt == 0) begin
                        core_ready <= 1'b1;
                        m_state    <= 2'd2;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: m_state <= 2'd0;
            endcase
        end
    end

    task automatic test_reset();
        p0_valid = 1'b1;
        p0_rdwr  = 1'b1;
        p0_addr  = 32'h100;
        #1 rst_n = 1'b0;
        #15;
        checks++;
        if ({core_valid, core_cflg, core_rdwr, init_done, busy, sw_ack, p0_rvalid, p1_rvalid,
             p0_ready, p1_ready} !== 10'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0", {core_valid, core_cflg, core_rdwr,
                     init_done, busy, sw_ack, p0_rvalid, p1_rvalid, p0_ready, p1_ready});
        end
        checks++;
        if ({core_ccmd, core_addr, core_cfg_addr, core_wdata} !== 136'h0) begin
            errors++;
            $display("FAIL reset_fields: ccmd=%h addr=%h cfg_addr=%h wdata=%h want 0",
                     core_ccmd, core_addr, core_cfg_addr, core_wdata);
        end
        checks++;
        if ({sw_rdata, p0_rdata, p1_rdata} !== 136'h0) begin
            errors++;
            $display("FAIL reset_rdata: sw=%h p0=%h p1=%h want 0", sw_rdata, p0_rdata, p1_rdata);
        end
    endtask

    // p0 request stays asserted throughout init and must be held off
    task automatic test_init_holdoff();
        int base;
        logic early, held, seen;
        logic [4:0] ix;
        base = xfer_count;
        early = 1'b0;
        held = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            if (n < 16 && core_valid) early = 1'b1;
            if (p0_ready) held = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL init_early_valid: got %b want 0", early);
        end
        checks++;
        if ({core_valid, core_cflg, core_rdwr, core_ccmd} !== {3'b110, 8'hFF}) begin
            errors++;
            $display("FAIL init_grst_cmd: valid=%b cflg=%b rdwr=%b ccmd=%h want 1 1 0 ff",
                     core_valid, core_cflg, core_rdwr, core_ccmd);
        end
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (init_done) begin
                seen = 1'b1;
                break;
            end
            if (p0_ready) held = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL init_done_timeout: got %b want 1", seen);
        end
        checks++;
        if (held !== 1'b0) begin
            errors++;
            $display("FAIL init_holdoff: p0_ready seen=%b want 0", held);
        end
        checks++;
        if (xfer_count - base !== 2) begin
            errors++;
            $display("FAIL init_xfer_count: got %0d want 2", xfer_count - base);
        end
        ix = 5'(base + 1);
        checks++;
        if ({log_cflg[ix], log_rdwr[ix], log_ccmd[ix], log_cfg_addr[ix], log_cfg_wdata[ix]}
            !== {1'b1, 1'b0, 8'hC0, 32'h0, 8'h00}) begin
            errors++;
            $display("FAIL init_mr_cmd: cflg=%b rdwr=%b ccmd=%h addr=%h data=%h want 1 0 c0 0 0",
                     log_cflg[ix], log_rdwr[ix], log_ccmd[ix], log_cfg_addr[ix],
                     log_cfg_wdata[ix]);
        end
    endtask

    task automatic test_p0_read();
        int base;
        logic found;
        logic [4:0] ix;
        base = xfer_count;
        ix = 5'(base);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p0_ready) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL p0_grant: ready seen=%b want 1", found);
        end
        @(posedge clk);
        #1;
        p0_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (p0_rvalid) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1 || p0_rdata !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL p0_read_data: rvalid=%b rdata=%h want 1 1122334455667788",
                     found, p0_rdata);
        end
        checks++;
        if ({log_cflg[ix], log_rdwr[ix], log_addr[ix]} !== {1'b0, 1'b1, 32'h100}) begin
            errors++;
            $display("FAIL p0_read_cmd: cflg=%b rdwr=%b addr=%h want 0 1 100",
                     log_cflg[ix], log_rdwr[ix], log_addr[ix]);
        end
        @(negedge clk);
        checks++;
        if (p0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL p0_rvalid_pulse: got %b want 0", p0_rvalid);
        end
    endtask

    task automatic test_round_robin();
        int base, g;
        logic bad;
        logic [7:0] seq;
        logic [4:0] ix;
        base = xfer_count;
        g = 0;
        bad = 1'b0;
        @(posedge clk);
        #1;
        p1_valid = 1'b1;
        p1_rdwr  = 1'b0;
        p1_addr  = 32'h200;
        p1_wdata = 64'hA5A5_0000_FFFF_1234;
        p1_wmask = 8'h0F;
        for (int c = 0; c < 200 && g < 2; c++) begin
            @(negedge clk);
            if (p1_ready) g++;
            if (p0_ready) bad = 1'b1;
        end
        @(posedge clk);
        #1;
        p1_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checks++;
        if (g !== 2 || bad !== 1'b0 || xfer_count - base !== 2) begin
            errors++;
            $display("FAIL lone_p1_b2b: grants=%0d stray_p0=%b xfers=%0d want 2 0 2",
                     g, bad, xfer_count - base);
        end
        ix = 5'(base + 1);
        checks++;
        if ({log_cflg[ix], log_rdwr[ix], log_addr[ix], log_wdata[ix], log_wmask[ix]}
            !== {1'b0, 1'b0, 32'h200, 64'hA5A5_0000_FFFF_1234, 8'h0F}) begin
            errors++;
            $display("FAIL p1_write_cmd: cflg=%b rdwr=%b addr=%h wdata=%h wmask=%h",
                     log_cflg[ix], log_rdwr[ix], log_addr[ix], log_wdata[ix], log_wmask[ix]);
        end
        g = 0;
        seq = 8'h00;
        @(posedge clk);
        #1;
        p0_valid = 1'b1;
        p0_rdwr  = 1'b1;
        p0_addr  = 32'h180;
        p1_valid = 1'b1;
        for (int c = 0; c < 300 && g < 4; c++) begin
            @(negedge clk);
            if (p0_ready && p1_ready) bad = 1'b1;
            if (p0_ready) begin
                seq = {seq[5:0], 2'd0};
                g++;
            end else if (p1_ready) begin
                seq = {seq[5:0], 2'd1};
                g++;
            end
        end
        @(posedge clk);
        #1;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checks++;
        if (seq !== 8'h11 || bad !== 1'b0) begin
            errors++;
            $display("FAIL rr_order: seq=%h dual_ready=%b want 11 0", seq, bad);
        end
    endtask

    task automatic test_sw_priority();
        int base;
        logic found, early, stray;
        logic [4:0] ix;
        base = xfer_count;
        ix = 5'(base);
        found = 1'b0;
        early = 1'b0;
        stray = 1'b0;
        @(posedge clk);
        #1;
        sw_req   = 1'b1;
        sw_rdwr  = 1'b1;
        sw_ccmd  = 8'h40;
        sw_addr  = 32'h3;
        p0_valid = 1'b1;
        p0_rdwr  = 1'b0;
        p0_addr  = 32'h300;
        p0_wdata = 64'hDEAD_BEEF_0000_0001;
        p0_wmask = 8'hFF;
        @(negedge clk);
        checks++;
        if (p0_ready !== 1'b0) begin
            errors++;
            $display("FAIL sw_priority: p0_ready=%b want 0", p0_ready);
        end
        @(posedge clk);
        #1;
        sw_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (p0_ready) early = 1'b1;
            if (sw_ack) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1 || sw_rdata !== 8'h8D || early !== 1'b0) begin
            errors++;
            $display("FAIL sw_read: ack=%b rdata=%h p0_early=%b want 1 8d 0",
                     found, sw_rdata, early);
        end
        checks++;
        if ({log_cflg[ix], log_rdwr[ix], log_ccmd[ix], log_cfg_addr[ix], log_wdata[ix],
             log_wmask[ix]} !== {1'b1, 1'b1, 8'h40, 32'h3, 64'h0, 8'h00}) begin
            errors++;
            $display("FAIL sw_cmd: cflg=%b rdwr=%b ccmd=%h cfg_addr=%h wdata=%h wmask=%h",
                     log_cflg[ix], log_rdwr[ix], log_ccmd[ix], log_cfg_addr[ix],
                     log_wdata[ix], log_wmask[ix]);
        end
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (p0_ready) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL p0_after_sw: ready seen=%b want 1", found);
        end
        // Short sw pulse while the core is busy must never be accepted
        @(posedge clk);
        #1;
        p0_valid = 1'b0;
        sw_req   = 1'b1;
        @(posedge clk);
        #1;
        sw_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sw_ack) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0 || xfer_count - base !== 2) begin
            errors++;
            $display("FAIL sw_dropped: ack=%b xfers=%0d want 0 2", stray, xfer_count - base);
        end
    endtask

    task automatic test_reset_mid();
        logic found, pulse, early;
        found = 1'b0;
        pulse = 1'b0;
        early = 1'b0;
        @(posedge clk);
        #1;
        p1_valid = 1'b1;
        p1_rdwr  = 1'b1;
        p1_addr  = 32'h400;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (p1_ready) break;
        end
        @(posedge clk);
        #1;
        p1_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy && !core_valid && !core_ready) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL mid_wait_lo: reached=%b want 1", found);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({core_valid, core_rdwr, init_done, busy, p1_rvalid, core_addr} !== 37'h0) begin
            errors++;
            $display("FAIL mid_reset_clear: valid=%b rdwr=%b done=%b busy=%b rvalid=%b addr=%h",
                     core_valid, core_rdwr, init_done, busy, p1_rvalid, core_addr);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            if (n < 16 && core_valid) early = 1'b1;
            if (p1_rvalid) pulse = 1'b1;
        end
        checks++;
        if (early !== 1'b0 || {core_valid, core_ccmd} !== {1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL mid_restart: early=%b valid=%b ccmd=%h want 0 1 ff",
                     early, core_valid, core_ccmd);
        end
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (p1_rvalid) pulse = 1'b1;
            if (init_done) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (pulse !== 1'b0 || found !== 1'b1) begin
            errors++;
            $display("FAIL mid_no_pulse: rvalid=%b reinit_done=%b want 0 1", pulse, found);
        end
    endtask

    initial begin
        test_reset();
        test_init_holdoff();
        test_p0_read();
        test_round_robin();
        test_sw_priority();
        test_reset_mid();
        checks++;
        if (model_err !== 0) begin
            errors++;
            $display("FAIL field_stability: unstable cycles=%0d want 0", model_err);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
